muldiv_sequencer: RTL and testbench

//  Sequences the shared multiplier/divisor pair for MULT/DIV on behalf of the main control FSM.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_timer.sv | 28 ++
 rtl/muldiv_sequencer.sv | 150 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and codes for the MULT/DIV sequencer.
// State encoding, exception codes and operation select values.
package muldiv_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_WRITE,
      S_DONE,
      S_EXC
   } state_t;

   localparam logic [1:0] EXC_NONE    = 2'd0;
   localparam logic [1:0] EXC_DIV0    = 2'd1;
   localparam logic [1:0] EXC_TIMEOUT = 2'd2;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_timer.sv
// Clear/enable up-counter with terminal-count compare against a runtime limit.
// Holds at the limit, so it never wraps.
module muldiv_timer #(
   parameter int W = 6
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [W-1:0] i_limit,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   assign o_tc = (r_cnt == i_limit);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_tc) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier/divisor: start pulse, wait for fim,
// then load HI/LO or raise a divide-by-zero / timeout exception.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int START_HOLD     = 1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req,
   input  logic       req_div,
   input  logic       abort,
   input  logic       mult_fim,
   input  logic       div_fim,
   input  logic       div_by_zero,
   output logic       mult_start,
   output logic       div_start,
   output logic       hi_sel,
   output logic       lo_sel,
   output logic       hi_write,
   output logic       lo_write,
   output logic       busy,
   output logic       done,
   output logic       exc,
   output logic [1:0] exc_code
);

   localparam int TW_T = $clog2(TIMEOUT_CYCLES);
   localparam int TW_S = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
   localparam int TW   = (TW_T > TW_S) ? TW_T : TW_S;

   localparam logic [TW-1:0] LIM_START = TW'(START_HOLD - 1);
   localparam logic [TW-1:0] LIM_WAIT  = TW'(TIMEOUT_CYCLES - 1);

   state_t          r_state;
   state_t          w_next;
   logic            r_op;
   logic [1:0]      r_code;
   logic [1:0]      w_code;
   logic            w_fim;
   logic            w_tc;
   logic            w_tmr_clr;
   logic            w_tmr_en;
   logic [TW-1:0]   w_limit;

   // One counter serves both the start-hold and the wait timeout.
   assign w_tmr_clr = (w_next != r_state);
   assign w_tmr_en  = (r_state == S_START) || (r_state == S_WAIT);
   assign w_limit   = (r_state == S_START) ? LIM_START : LIM_WAIT;
   assign w_fim     = (r_op == OP_DIV) ? div_fim : mult_fim;

   muldiv_timer #(
      .W(TW)
   ) u_timer (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_clr   (w_tmr_clr),
      .i_en    (w_tmr_en),
      .i_limit (w_limit),
      .o_tc    (w_tc)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_op    <= OP_MULT;
         r_code  <= EXC_NONE;
      end else begin
         r_state <= w_next;
         r_code  <= w_code;
         if (r_state == S_IDLE && w_next == S_START) begin
            r_op <= req_div;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      w_code = EXC_NONE;
      unique case (r_state)
         S_IDLE: begin
            if (req && !abort) w_next = S_START;
         end
         S_START: begin
            if (abort)     w_next = S_IDLE;
            else if (w_tc) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (abort) begin
               w_next = S_IDLE;
            end else if (r_op == OP_DIV && div_by_zero) begin
               w_next = S_EXC;
               w_code = EXC_DIV0;
            end else if (w_fim) begin
               w_next = S_WRITE;
            end else if (w_tc) begin
               w_next = S_EXC;
               w_code = EXC_TIMEOUT;
            end
         end
         S_WRITE: w_next = abort ? S_IDLE : S_DONE;
         S_DONE:  w_next = S_IDLE;
         S_EXC:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      mult_start = 1'b0;
      div_start  = 1'b0;
      hi_sel     = 1'b0;
      lo_sel     = 1'b0;
      hi_write   = 1'b0;
      lo_write   = 1'b0;
      done       = 1'b0;
      exc        = 1'b0;
      exc_code   = EXC_NONE;
      busy       = (r_state != S_IDLE);
      unique case (r_state)
         S_START: begin
            mult_start = (r_op == OP_MULT);
            div_start  = (r_op == OP_DIV);
            hi_sel     = r_op;
            lo_sel     = r_op;
         end
         S_WAIT: begin
            hi_sel = r_op;
            lo_sel = r_op;
         end
         S_WRITE: begin
            hi_sel   = r_op;
            lo_sel   = r_op;
            hi_write = 1'b1;
            lo_write = 1'b1;
         end
         S_DONE: begin
            hi_sel = r_op;
            lo_sel = r_op;
            done   = 1'b1;
         end
         S_EXC: begin
            exc      = 1'b1;
            exc_code = r_code;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against a
// transaction-level timeline model.
module tb_muldiv_sequencer;

   localparam int H = 1;
   localparam int T = 8;

   logic       clock = 1'b0;
   logic       reset;
   logic       req, req_div, abort;
   logic       mult_fim, div_fim, div_by_zero;
   logic       mult_start, div_start, hi_sel, lo_sel;
   logic       hi_write, lo_write, busy, done, exc;
   logic [1:0] exc_code;

   int n_tests = 0;
   int n_fail  = 0;

   muldiv_sequencer #(
      .START_HOLD     (H),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .req_div     (req_div),
      .abort       (abort),
      .mult_fim    (mult_fim),
      .div_fim     (div_fim),
      .div_by_zero (div_by_zero),
      .mult_start  (mult_start),
      .div_start   (div_start),
      .hi_sel      (hi_sel),
      .lo_sel      (lo_sel),
      .hi_write    (hi_write),
      .lo_write    (lo_write),
      .busy        (busy),
      .done        (done),
      .exc         (exc),
      .exc_code    (exc_code)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] outs();
      return {mult_start, div_start, hi_sel, lo_sel, hi_write,
              lo_write, busy, done, exc, exc_code};
   endfunction

   function automatic logic [10:0] mk(bit ms, bit ds, bit sel, bit wr,
                                      bit bz, bit dn, bit ex,
                                      logic [1:0] code);
      return {ms, ds, sel, sel, wr, wr, bz, dn, ex, code};
   endfunction

   task automatic drive_idle();
      req = 0; req_div = 0; abort = 0;
      mult_fim = 0; div_fim = 0; div_by_zero = 0;
   endtask

   // One request from the IDLE cycle (c=0) to its last busy cycle.
   // kind: 0 abort, 1 write, 2 div-by-zero, 3 timeout.
   task automatic run_txn(input string id, input bit op, input int fim_c,
                          input int dz_c, input int stray_c,
                          input int abort_c, input int noise);
      int w0, e, kind, last;
      logic [10:0] exp;
      w0 = H + 1;
      e = -1;
      kind = 0;
      for (int c = 1; c < w0 + T && e < 0; c++) begin
         if (c == abort_c) begin
            e = c; kind = 0;
         end else if (c >= w0) begin
            if (op && c == dz_c) begin
               e = c; kind = 2;
            end else if (c == fim_c) begin
               e = c; kind = 1;
            end else if (c == w0 + T - 1) begin
               e = c; kind = 3;
            end
         end
      end
      last = (kind == 0) ? e : (kind == 1) ? e + 2 : e + 1;
      if (kind != 0 && abort_c > e && abort_c < last) last = abort_c;
      for (int c = 0; c <= last; c++) begin
         if (c == 0) req = 1;
         else if (noise == 1) req = 1'($urandom);
         else if (noise == 2) req = 1;
         else req = 0;
         req_div = (c == 0 || noise == 0) ? op : 1'($urandom);
         abort = (c == abort_c);
         mult_fim = op ? (c == stray_c) : (c == fim_c);
         div_fim = op ? (c == fim_c) : (c == stray_c);
         div_by_zero = (c == dz_c);
         if (c == 0) exp = '0;
         else if (c <= e) exp = mk(!op && c <= H, op && c <= H, op, 0, 1, 0, 0, 0);
         else if (kind == 1 && c == e + 1) exp = mk(0, 0, op, 1, 1, 0, 0, 0);
         else if (kind == 1) exp = mk(0, 0, op, 0, 1, 1, 0, 0);
         else exp = mk(0, 0, 0, 0, 1, 0, 1, (kind == 2) ? 2'd1 : 2'd2);
         @(negedge clock);
         check($sformatf("%s c%0d", id, c), 32'(outs()), 32'(exp));
         @(posedge clock);
         #1;
      end
      drive_idle();
   endtask

   // IDLE cycles; a req here always comes with abort, so it is dropped.
   task automatic idle_cycles(input string id, input int n);
      for (int c = 0; c < n; c++) begin
         abort = 1'($urandom);
         req = abort & 1'($urandom);
         req_div = 1'($urandom);
         mult_fim = 1'($urandom);
         div_fim = 1'($urandom);
         div_by_zero = 1'($urandom);
         @(negedge clock);
         check($sformatf("%s idle%0d", id, c), 32'(outs()), 32'd0);
         @(posedge clock);
         #1;
      end
      drive_idle();
   endtask

   initial begin
      drive_idle();
      reset = 1;
      #2;
      check("reset_outs", 32'(outs()), 32'd0);
      @(negedge clock);
      reset = 0;
      @(posedge clock);
      #1;

      run_txn("mult_basic", 0, 4, -1, -1, -1, 0);
      idle_cycles("post_mult", 1);
      run_txn("div_by_zero", 1, 3, 3, -1, -1, 0);
      idle_cycles("post_dz", 1);
      run_txn("timeout", 0, -1, -1, -1, -1, 0);
      run_txn("abort_wait", 1, -1, -1, -1, 3, 0);
      run_txn("after_abort", 0, 2, -1, -1, -1, 0);
      run_txn("min_latency", 1, 2, -1, -1, -1, 0);
      run_txn("stray_fim", 1, 6, -1, 3, -1, 0);
      run_txn("mult_dz_ign", 0, 5, 3, 4, -1, 0);
      run_txn("abort_start", 0, -1, -1, -1, 1, 0);
      run_txn("abort_write", 1, 3, -1, -1, 4, 0);
      run_txn("b2b_a", 0, 3, -1, -1, -1, 2);
      run_txn("b2b_b", 1, 5, -1, -1, -1, 2);
      idle_cycles("abort_req", 4);

      // Reset asserted between edges while in WAIT.
      req = 1; req_div = 1;
      @(posedge clock); #1;
      req = 0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("pre_reset_wait", 32'(outs()), 32'(mk(0, 0, 1, 0, 1, 0, 0, 0)));
      #2;
      reset = 1;
      #1;
      check("async_reset", 32'(outs()), 32'd0);
      @(negedge clock);
      reset = 0;
      @(posedge clock); #1;
      check("post_reset", 32'(outs()), 32'd0);

      for (int i = 0; i < 40; i++) begin
         bit op;
         int fc, dz, st, ab;
         op = 1'($urandom);
         fc = ($urandom % 4 == 0) ? -1 : int'($urandom_range(1, 11));
         dz = ($urandom % 3 == 0) ? int'($urandom_range(1, 11)) : -1;
         st = int'($urandom_range(1, 11));
         ab = ($urandom % 5 == 0) ? int'($urandom_range(1, 12)) : -1;
         run_txn($sformatf("rnd%0d", i), op, fc, dz, st, ab, 1);
         if ($urandom % 2 == 0) idle_cycles($sformatf("rnd%0d", i), 2);
      end
      idle_cycles("final", 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
